debounce_multi: RTL and testbench

- Parametrised N-channel successor to the single-input debouncer.
- Each channel has a 2-flop synchroniser, a stability counter of configurable length and a clean level output.
- Each channel also produces registered one-cycle rising and falling edge strobes.
- Sits between raw board inputs (keys, switches, GPIO) and core logic; all outputs are synchronous to clk.

---
 rtl/debounce_multi.sv | 110 +++++++++++
 tb/tb_debounce_multi.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// debounce_multi: per-channel 2-flop synchroniser, stability counter and registered edge strobes.
// Latency: clean_out follows a stable input change after STABLE_CYCLES+2 edges; strobes align with the new level.
// Backpressure: none, free-running; DEBOUNCE_REPEAT_EN adds hold/auto-repeat strobes (repeat_pulse).
module debounce_multi #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 16384,
  parameter int RESET_LEVEL   = 0
`ifdef DEBOUNCE_REPEAT_EN
  ,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] bouncy_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse
`ifdef DEBOUNCE_REPEAT_EN
  ,
  output logic [N_CH-1:0] repeat_pulse
`endif
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic             RL       = (RESET_LEVEL != 0);

  logic [N_CH-1:0]  meta;
  logic [N_CH-1:0]  sync;
  logic [N_CH-1:0]  flip;
  logic [CNT_W-1:0] cnt [N_CH];

  // flip[i]: this edge is the terminal count, clean_out[i] takes sync[i]
  always_comb begin
    flip = '0;
    for (int i = 0; i < N_CH; i++) begin
      flip[i] = (sync[i] != clean_out[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta       <= {N_CH{RL}};
      sync       <= {N_CH{RL}};
      clean_out  <= {N_CH{RL}};
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      meta       <= bouncy_in;
      sync       <= meta;
      clean_out  <= clean_out ^ flip;
      rise_pulse <= flip & sync;
      fall_pulse <= flip & ~sync;
      for (int i = 0; i < N_CH; i++) begin
        if ((sync[i] == clean_out[i]) || flip[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam int                REP_W     = $clog2(REPEAT_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic [N_CH-1:0]   clean_nxt;
  logic [HOLD_W-1:0] hold_cnt [N_CH];
  logic [REP_W-1:0]  rep_cnt  [N_CH];

  assign clean_nxt = clean_out ^ flip;

  // hold_cnt = cycles since the rise cycle, saturating at HOLD_CYCLES; rep_cnt then paces repeats
  always_ff @(posedge clk) begin
    if (rst) begin
      repeat_pulse <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hold_cnt[i] <= '0;
        rep_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        repeat_pulse[i] <= 1'b0;
        if (!clean_nxt[i] || (flip[i] && sync[i])) begin
          hold_cnt[i] <= '0;
          rep_cnt[i]  <= '0;
        end else if (hold_cnt[i] != HOLD_LAST) begin
          hold_cnt[i]     <= hold_cnt[i] + HOLD_W'(1);
          rep_cnt[i]      <= '0;
          repeat_pulse[i] <= (hold_cnt[i] == HOLD_LAST - HOLD_W'(1));
        end else if (rep_cnt[i] == REP_LAST) begin
          rep_cnt[i]      <= '0;
          repeat_pulse[i] <= 1'b1;
        end else begin
          rep_cnt[i] <= rep_cnt[i] + REP_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios plus a randomized run against a sliding-window model.
module tb_debounce_multi;
  localparam int   N_CH = 2;
  localparam int   S    = 4;
  localparam logic RL   = 1'b0;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] bouncy_in = '0;
  logic [N_CH-1:0] clean_out;
  logic [N_CH-1:0] rise_pulse;
  logic [N_CH-1:0] fall_pulse;
`ifdef DEBOUNCE_REPEAT_EN
  logic [N_CH-1:0] repeat_pulse;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #10 clk = ~clk;

  debounce_multi #(
    .N_CH(N_CH),
    .STABLE_CYCLES(S),
    .RESET_LEVEL(0)
`ifdef DEBOUNCE_REPEAT_EN
    ,
    .HOLD_CYCLES(10),
    .REPEAT_CYCLES(3)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bouncy_in(bouncy_in),
    .clean_out(clean_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
`ifdef DEBOUNCE_REPEAT_EN
    ,
    .repeat_pulse(repeat_pulse)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bouncy_in = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_cnt++;
      if ({clean_out, rise_pulse, fall_pulse} !== 6'b00_00_00)
        $display("FAIL reset_hold cyc%0d: got %b want 000000", i, {clean_out, rise_pulse, fall_pulse});
      else pass_cnt++;
    end
    rst = 1'b0;
    tick(1);
    chk_cnt++;
    if ({clean_out, rise_pulse, fall_pulse} !== 6'b00_00_00)
      $display("FAIL reset_release: got %b want 000000", {clean_out, rise_pulse, fall_pulse});
    else pass_cnt++;
    bouncy_in = 2'b00;
    tick(8);
  endtask

  task automatic test_clean_step();
    bouncy_in = 2'b01;
    tick(5);
    chk_cnt++;
    if ({clean_out, rise_pulse, fall_pulse} !== 6'b00_00_00)
      $display("FAIL step_early: got %b want 000000", {clean_out, rise_pulse, fall_pulse});
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if ({clean_out, rise_pulse, fall_pulse} !== 6'b01_01_00)
      $display("FAIL step_edge: got %b want 010100", {clean_out, rise_pulse, fall_pulse});
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if ({clean_out, rise_pulse, fall_pulse} !== 6'b01_00_00)
      $display("FAIL step_after: got %b want 010000", {clean_out, rise_pulse, fall_pulse});
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    int bad;
    bouncy_in = 2'b00;
    tick(8);
    bad = 0;
    // 1,0,1,0 toggles, a 3-cycle high, then low long enough to settle
    for (int t = 0; t < 15; t++) begin
      bouncy_in[0] = (t < 4) ? (t % 2 == 0) : (t < 7);
      tick(1);
      if (clean_out[0] || rise_pulse[0] || fall_pulse[0]) bad++;
    end
    chk_cnt++;
    if (bad != 0) $display("FAIL bounce_reject: got %0d bad cycles want 0", bad);
    else pass_cnt++;
    bouncy_in[0] = 1'b1;
    tick(5);
    chk_cnt++;
    if (clean_out[0] !== 1'b0) $display("FAIL bounce_hold_early: got %b want 0", clean_out[0]);
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if ({clean_out[0], rise_pulse[0]} !== 2'b11)
      $display("FAIL bounce_hold_rise: got %b want 11", {clean_out[0], rise_pulse[0]});
    else pass_cnt++;
  endtask

  task automatic test_fall_indep();
    int ch0_bad;
    int falls;
    bouncy_in = 2'b11;
    tick(8);
    bouncy_in = 2'b01;
    ch0_bad = 0;
    falls = 0;
    for (int t = 0; t < 12; t++) begin
      tick(1);
      if ({clean_out[0], rise_pulse[0], fall_pulse[0]} !== 3'b100) ch0_bad++;
      if (fall_pulse[1]) falls++;
      if (t == 5) begin
        chk_cnt++;
        if ({clean_out[1], fall_pulse[1], rise_pulse[1]} !== 3'b010)
          $display("FAIL fall_ch1_edge: got %b want 010", {clean_out[1], fall_pulse[1], rise_pulse[1]});
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (falls != 1) $display("FAIL fall_ch1_once: got %0d strobes want 1", falls);
    else pass_cnt++;
    chk_cnt++;
    if (ch0_bad != 0) $display("FAIL fall_ch0_indep: got %0d bad cycles want 0", ch0_bad);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    bouncy_in = 2'b00;
    tick(8);
    bouncy_in = 2'b01;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk_cnt++;
    if ({clean_out, rise_pulse, fall_pulse} !== 6'b00_00_00)
      $display("FAIL midrst_clear: got %b want 000000", {clean_out, rise_pulse, fall_pulse});
    else pass_cnt++;
    rst = 1'b0;
    tick(5);
    chk_cnt++;
    if ({clean_out[0], rise_pulse[0]} !== 2'b00)
      $display("FAIL midrst_restart: got %b want 00", {clean_out[0], rise_pulse[0]});
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if ({clean_out[0], rise_pulse[0]} !== 2'b11)
      $display("FAIL midrst_rise: got %b want 11", {clean_out[0], rise_pulse[0]});
    else pass_cnt++;
  endtask

`ifdef DEBOUNCE_REPEAT_EN
  task automatic test_repeat();
    int  k;
    int  bad;
    bit  fell;
    bouncy_in = 2'b00;
    tick(8);
    bouncy_in = 2'b01;
    k = 0;
    tick(1);
    while (!rise_pulse[0] && k < 20) begin
      tick(1);
      k++;
    end
    chk_cnt++;
    if (rise_pulse[0] !== 1'b1) $display("FAIL rep_rise_seen: got %b want 1", rise_pulse[0]);
    else pass_cnt++;
    for (int j = 1; j <= 18; j++) begin
      tick(1);
      chk_cnt++;
      if (repeat_pulse[0] !== ((j == 10) || (j == 13) || (j == 16)))
        $display("FAIL rep_timing rise+%0d: got %b want %b", j, repeat_pulse[0], (j == 10) || (j == 13) || (j == 16));
      else pass_cnt++;
    end
    bouncy_in = 2'b00;
    fell = 1'b0;
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      tick(1);
      if (!clean_out[0]) fell = 1'b1;
      if (fell && repeat_pulse[0]) bad++;
    end
    chk_cnt++;
    if (!fell || bad != 0) $display("FAIL rep_stop: got fell=%0d repeats=%0d want fell=1 repeats=0", fell, bad);
    else pass_cnt++;
  endtask
`endif

  // Model: clean flips at edge c when the last S synchronised samples all differ from it
  // and none of them predates the previous flip/reset; sync(k) is the input sampled at edge k-1.
  task automatic test_random();
    logic [N_CH-1:0] in_hist [0:4095];
    int              last_evt [N_CH];
    int              run [N_CH];
    int              last_rst;
    logic [N_CH-1:0] m_clean, m_rise, m_fall;
    logic            r, sv;
    bit              ok;
    last_rst = 0;
    m_clean = {N_CH{RL}};
    for (int ch = 0; ch < N_CH; ch++) begin
      last_evt[ch] = 0;
      run[ch] = 0;
    end
    for (int c = 1; c <= 3000; c++) begin
      rst = (c == 1) || ($urandom_range(0, 199) == 0);
      for (int ch = 0; ch < N_CH; ch++) begin
        if (run[ch] == 0) begin
          bouncy_in[ch] = ~bouncy_in[ch];
          run[ch] = ($urandom_range(0, 2) == 0) ? $urandom_range(4, 9) : $urandom_range(1, 4);
        end
        run[ch]--;
      end
      in_hist[c] = bouncy_in;
      r = rst;
      tick(1);
      m_rise = '0;
      m_fall = '0;
      if (r) begin
        m_clean = {N_CH{RL}};
        last_rst = c;
        for (int ch = 0; ch < N_CH; ch++) last_evt[ch] = c;
      end else begin
        for (int ch = 0; ch < N_CH; ch++) begin
          if (c - S >= last_evt[ch]) begin
            ok = 1'b1;
            for (int k = c - S; k < c; k++) begin
              sv = (k - 1 <= last_rst) ? RL : in_hist[k-1][ch];
              if (sv == m_clean[ch]) ok = 1'b0;
            end
            if (ok) begin
              m_clean[ch] = ~m_clean[ch];
              last_evt[ch] = c;
              if (m_clean[ch]) m_rise[ch] = 1'b1;
              else m_fall[ch] = 1'b1;
            end
          end
        end
      end
      chk_cnt++;
      if ({clean_out, rise_pulse, fall_pulse} !== {m_clean, m_rise, m_fall})
        $display("FAIL rand_model c%0d: got %b want %b", c, {clean_out, rise_pulse, fall_pulse}, {m_clean, m_rise, m_fall});
      else pass_cnt++;
      chk_cnt++;
      if ((rise_pulse & fall_pulse) !== '0)
        $display("FAIL rand_excl c%0d: got rise&fall=%b want 00", c, rise_pulse & fall_pulse);
      else pass_cnt++;
    end
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_fall_indep();
    test_mid_reset();
`ifdef DEBOUNCE_REPEAT_EN
    test_repeat();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
